// File: rtl/ram32_arbiter_pkg.sv
// Shared definitions for the two-port RAM32 byte arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package ram32_arbiter_pkg;

  localparam int RAM_WORDS = 32;
  localparam int WORD_W    = 32;
  localparam int LANES     = 4;
  localparam int ADDR_W    = $clog2(RAM_WORDS);
  localparam int LANE_W    = $clog2(LANES);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Byte-lane write strobe: lane 0 maps to bit 0.
  function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    lane_onehot = LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/ram32_arb_pick.sv
// Two-way grant picker; round-robin when RAM32_ARB_RR_EN is defined, else fixed priority to requester 0.
// Latency: grants are combinational from requests in the same cycle; pointer updates on the clock edge.
// Backpressure: the losing requester simply receives no grant and must hold its request.
module ram32_arb_pick
  import ram32_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef RAM32_ARB_RR_EN
  // 1 when requester 1 was served by the most recent grant.
  logic r_last1;

  // On contention the requester that was not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = r_last1;
      gnt1 = ~r_last1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Pointer follows every grant; reset marks requester 0 as last served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last1 <= 1'b0;
    end else if (gnt0) begin
      r_last1 <= 1'b0;
    end else if (gnt1) begin
      r_last1 <= 1'b1;
    end
  end
`else
  // Fixed priority needs no state, so clock and reset are intentionally unused here.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst_n;

  // Requester 0 always wins on contention.
  always_comb begin
    gnt0 = req0;
    gnt1 = req1 & ~req0;
  end
`endif

endmodule

// File: rtl/ram32_arbiter.sv
// Arbitrates two byte-wide requesters onto one 32x32 RAM, clearing the RAM after every reset.
// Latency: grant and RAM access in the request cycle; read data (rvalidX) exactly one cycle later.
// Backpressure: busy during the 32-cycle clear; a requester without gnt holds its request. Optional RAM32_ARB_RR_EN.
module ram32_arbiter
  import ram32_arbiter_pkg::*;
#(
  parameter logic [WORD_W-1:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [6:0]          addr0,
  input  logic [6:0]          addr1,
  input  logic [7:0]          wdata0,
  input  logic [7:0]          wdata1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [7:0]          rdata,
  output logic                busy,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_a,
  output logic [LANES-1:0]    ram_we,
  output logic [WORD_W-1:0]   ram_di,
  input  logic [WORD_W-1:0]   ram_do
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_rv0;
  logic                r_rv1;
  logic [LANE_W-1:0]   r_lane;

  logic                w_run;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_we;
  logic [6:0]          w_addr;
  logic [7:0]          w_wdata;
  logic [LANE_W-1:0]   w_lane;

  // Requests only reach the picker while running and out of reset.
  assign w_run = rst_n & (r_state == ST_RUN);

  ram32_arb_pick u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0 & w_run),
    .req1  (req1 & w_run),
    .gnt0  (w_gnt0),
    .gnt1  (w_gnt1)
  );

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

  // Steer the winning requester's access fields.
  assign w_we    = w_gnt1 ? we1    : we0;
  assign w_addr  = w_gnt1 ? addr1  : addr0;
  assign w_wdata = w_gnt1 ? wdata1 : wdata0;
  assign w_lane  = w_addr[LANE_W-1:0];

  // State and clear-counter register; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and RAM port drive; reset forces the idle/busy view regardless of state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b1;
    ram_en      = 1'b0;
    ram_a       = '0;
    ram_we      = '0;
    ram_di      = '0;
    if (rst_n) begin
      case (r_state)
        ST_CLEAR: begin
          ram_en    = 1'b1;
          ram_a     = r_cnt;
          ram_we    = '1;
          ram_di    = CLEAR_VALUE;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == ADDR_W'(RAM_WORDS - 1)) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          busy = 1'b0;
          if (w_gnt0 || w_gnt1) begin
            ram_en = 1'b1;
            ram_a  = w_addr[6:LANE_W];
            if (w_we) begin
              ram_we = lane_onehot(w_lane);
              ram_di = WORD_W'(w_wdata) << {w_lane, 3'b000};
            end
          end
        end
        default: begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Remember which requester issued a read, and its byte lane, for next-cycle return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rv0  <= 1'b0;
      r_rv1  <= 1'b0;
      r_lane <= '0;
    end else begin
      r_rv0 <= w_gnt0 & ~we0;
      r_rv1 <= w_gnt1 & ~we1;
      if (w_gnt0 || w_gnt1) begin
        r_lane <= w_lane;
      end
    end
  end

  // A reset arriving right after a read grant suppresses the pending return.
  assign rvalid0 = r_rv0 & rst_n;
  assign rvalid1 = r_rv1 & rst_n;
  assign rdata   = ram_do[{r_lane, 3'b000} +: 8];

endmodule

// File: tb/tb_ram32_arbiter.sv
// Bench for ram32_arbiter: behavioural RAM32, byte-level reference memory and read-return scoreboard.
// Latency: expects grants in the request cycle and read data one cycle after the grant.
// Backpressure: contention patterns follow RAM32_ARB_RR_EN exactly as the design is built.
module tb_ram32_arbiter;

  localparam logic [31:0] CV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [6:0]  addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [7:0]  rdata;
  logic        ram_en;
  logic [4:0]  ram_a;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram32_arbiter #(.CLEAR_VALUE(CV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
  );

  // Behavioural RAM32: byte-enabled write, synchronous read-first.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_do <= mem[ram_a];
      for (int l = 0; l < 4; l++)
        if (ram_we[l]) mem[ram_a][8*l +: 8] <= ram_di[8*l +: 8];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Byte-level reference memory and expected read returns {requester, byte}.
  logic [7:0] mdl [128];
  logic [8:0] exp_q [$];

  task automatic init_model();
    logic [31:0] cvv;
    cvv = CV;
    for (int i = 0; i < 128; i++) mdl[i] = cvv[8*(i%4) +: 8];
  endtask

  // Scoreboard: every granted read must come back on the next cycle with the reference byte.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      exp_q.delete();
    end else begin
      check("one_gnt", {31'd0, gnt0 & gnt1}, 32'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rvalid_id", {30'd0, rvalid1, rvalid0}, e[8] ? 32'd2 : 32'd1);
        if (rvalid0 || rvalid1) check("rdata", {24'd0, rdata}, {24'd0, e[7:0]});
      end else begin
        check("spurious_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      end
      if (gnt0) begin
        if (we0) mdl[addr0] = wdata0;
        else     exp_q.push_back({1'b0, mdl[addr0]});
      end else if (gnt1) begin
        if (we1) mdl[addr1] = wdata1;
        else     exp_q.push_back({1'b1, mdl[addr1]});
      end
    end
  end

  typedef struct {
    logic       r0; logic w0; logic [6:0] a0; logic [7:0] d0;
    logic       r1; logic w1; logic [6:0] a1; logic [7:0] d1;
    logic       eg0; logic eg1; logic een;
    logic [4:0] ea; logic [3:0] ewe; logic [31:0] edi;
  } vec_t;

  vec_t vec [10];

  task automatic drive_idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Checks n clear cycles for words 0..n-1 while both requesters try to get in.
  task automatic run_clear(input int n);
    for (int i = 0; i < n; i++) begin
      req0 = 1; req1 = 1;
      @(negedge clk);
      check("clr_busy", {31'd0, busy}, 32'd1);
      check("clr_en", {31'd0, ram_en}, 32'd1);
      check("clr_a", {27'd0, ram_a}, i);
      check("clr_we", {28'd0, ram_we}, 32'hF);
      check("clr_di", ram_di, CV);
      check("clr_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      next_cycle();
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic check_reset_view(input string nm);
    @(negedge clk);
    check({nm, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
    check({nm, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
    check({nm, "_en"}, {31'd0, ram_en}, 32'd0);
    check({nm, "_we"}, {28'd0, ram_we}, 32'd0);
    check({nm, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    vec[0] = '{0,0,7'h00,8'h00, 1,0,7'h45,8'h00, 0,1,1, 5'd17, 4'h0, 32'h0};
    vec[1] = '{1,1,7'h13,8'hA5, 0,0,7'h00,8'h00, 1,0,1, 5'd4,  4'b1000, 32'hA500_0000};
    vec[2] = '{0,0,7'h00,8'h00, 1,0,7'h13,8'h00, 0,1,1, 5'd4,  4'h0, 32'h0};
    vec[3] = '{0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0, 5'd0,  4'h0, 32'h0};
    vec[4] = '{0,0,7'h00,8'h00, 1,1,7'h7F,8'hC3, 0,1,1, 5'd31, 4'b1000, 32'hC300_0000};
    vec[5] = '{0,0,7'h00,8'h00, 1,1,7'h20,8'h11, 0,1,1, 5'd8,  4'b0001, 32'h0000_0011};
    vec[6] = '{1,1,7'h21,8'h22, 0,0,7'h00,8'h00, 1,0,1, 5'd8,  4'b0010, 32'h0000_2200};
    vec[7] = '{0,0,7'h00,8'h00, 1,1,7'h22,8'h33, 0,1,1, 5'd8,  4'b0100, 32'h0033_0000};
    vec[8] = '{1,1,7'h23,8'h44, 0,0,7'h00,8'h00, 1,0,1, 5'd8,  4'b1000, 32'h4400_0000};
    vec[9] = '{1,0,7'h22,8'h00, 0,0,7'h00,8'h00, 1,0,1, 5'd8,  4'h0, 32'h0};

    // Reset with both requesters active: nothing may be granted.
    drive_idle();
    rst_n = 0; req0 = 1; req1 = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_reset_view("rst");
      next_cycle();
    end
    rst_n = 1;
    run_clear(32);
    @(negedge clk);
    check("run_busy", {31'd0, busy}, 32'd0);
    next_cycle();
    init_model();

    // Single-requester accesses from the vector table.
    for (int v = 0; v < 10; v++) begin
      req0 = vec[v].r0; we0 = vec[v].w0; addr0 = vec[v].a0; wdata0 = vec[v].d0;
      req1 = vec[v].r1; we1 = vec[v].w1; addr1 = vec[v].a1; wdata1 = vec[v].d1;
      @(negedge clk);
      check($sformatf("v%0d_gnt", v), {30'd0, gnt1, gnt0}, {30'd0, vec[v].eg1, vec[v].eg0});
      check($sformatf("v%0d_en", v), {31'd0, ram_en}, {31'd0, vec[v].een});
      check($sformatf("v%0d_we", v), {28'd0, ram_we}, {28'd0, vec[v].ewe});
      if (vec[v].een) check($sformatf("v%0d_a", v), {27'd0, ram_a}, {27'd0, vec[v].ea});
      if (vec[v].ewe != 4'h0) check($sformatf("v%0d_di", v), ram_di, vec[v].edi);
      next_cycle();
    end
    drive_idle();
    @(negedge clk);
    check("word_8", ram_do, 32'h4433_2211);
    next_cycle();

    // Contention: both reads held for four back-to-back cycles.
    req0 = 1; addr0 = 7'h20; req1 = 1; addr1 = 7'h23;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef RAM32_ARB_RR_EN
      check($sformatf("rr%0d_gnt", i), {30'd0, gnt1, gnt0}, (i % 2 == 0) ? 32'd2 : 32'd1);
`else
      check($sformatf("fp%0d_gnt", i), {30'd0, gnt1, gnt0}, 32'd1);
`endif
      next_cycle();
    end
    drive_idle();
    next_cycle();

    // Read granted, then reset on the following cycle: its return must vanish.
    req0 = 1; addr0 = 7'h20;
    @(negedge clk);
    check("abort_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    next_cycle();
    drive_idle();
    rst_n = 0;
    check_reset_view("abort");
    next_cycle();
    rst_n = 1;

    // Reset at clear word 10 restarts the full 32-word clear.
    run_clear(10);
    rst_n = 0;
    check_reset_view("midclr");
    next_cycle();
    rst_n = 1;
    run_clear(32);
    init_model();
    @(negedge clk);
    check("reclr_busy", {31'd0, busy}, 32'd0);
    next_cycle();

    // Earlier writes must be wiped by the clear.
    req1 = 1; addr1 = 7'h20;
    next_cycle();
    drive_idle();
    next_cycle();
    next_cycle();
    check("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
